// File: rtl/backdoor_pkg.sv
// Shared definitions for the backdoor SPI bus bridge.
//   REG_IDX_W  : width of the register index field of a bridge address
//   MOD_SEL_W  : width of the module-select field of a bridge address
//   DATA_W     : data word width carried in a write entry
//   state_t    : write FSM states
//   wr_entry_t : one queued/active write {module, index, data}
package backdoor_pkg;

  localparam int REG_IDX_W = 4;
  localparam int MOD_SEL_W = 3;
  localparam int DATA_W    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [MOD_SEL_W-1:0] mod;
    logic [REG_IDX_W-1:0] index;
    logic [DATA_W-1:0]    data;
  } wr_entry_t;

endpackage

// File: rtl/backdoor_rd_mux.sv
// Registered readback select: picks one module's readback word out of the
// flattened bus and registers it for the SPI slave's parallel load.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   sel        : module select (bridge address bits [2:0])
//   rd_data    : flattened readback, module k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out   : selected word, one cycle after sel/rd_data
module backdoor_rd_mux
  import backdoor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_MODULES = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MOD_SEL_W-1:0]              sel,
  input  logic [NUM_MODULES*DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0]             data_out
);

  logic [DATA_WIDTH-1:0] slice [NUM_MODULES];

  for (genvar k = 0; k < NUM_MODULES; k++) begin : g_slice
    assign slice[k] = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---- stage p0 -> p1: register selected word ----
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else     data_out <= slice[sel];
  end

endmodule

// File: rtl/backdoor_bus_bridge.sv
// Backdoor bus bridge: turns completed SPI writes (address + data, flagged by
// a one-cycle valid pulse) into handshaked writes to one of eight user
// modules, keeps one write pending behind the active one, counts dropped
// writes, and drives the registered readback word back to the SPI slave.
//
// Optional feature macro: BACKDOOR_BRIDGE_TIMEOUT_EN
//   defined   : a write not acked within TIMEOUT_CYCLES cycles is aborted and
//               the sticky o_ERR flag is set.
//   undefined : writes wait for ack indefinitely, o_ERR is constant 0.
//
// Ports:
//   i_SYSCLK, i_RST : system clock, synchronous active-high reset
//   i_ADDR          : [6:3] register index, [2:0] module select
//   i_DATA_IN       : write data
//   i_DOUT_VALID    : one-cycle pulse, i_ADDR/i_DATA_IN hold a write
//   o_DATA_OUT      : registered readback word for the SPI slave
//   o_WR_EN         : one-hot write request
//   o_WR_ADDR       : register index of the active write
//   o_WR_DATA       : data of the active write
//   i_WR_ACK        : per-module write acknowledge
//   o_RD_ADDR       : register index presented for readback (combinational)
//   i_RD_DATA       : flattened readback from all modules
//   o_BUSY          : a write is active or pending
//   o_ERR           : sticky write-timeout flag
//   o_DROP_CNT      : saturating dropped-write count
module backdoor_bus_bridge
  import backdoor_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_MODULES    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              i_SYSCLK,
  input  logic                              i_RST,
  input  logic [ADDRESS_WIDTH-2:0]          i_ADDR,
  input  logic [DATA_WIDTH-1:0]             i_DATA_IN,
  input  logic                              i_DOUT_VALID,
  output logic [DATA_WIDTH-1:0]             o_DATA_OUT,
  output logic [NUM_MODULES-1:0]            o_WR_EN,
  output logic [REG_IDX_W-1:0]              o_WR_ADDR,
  output logic [DATA_WIDTH-1:0]             o_WR_DATA,
  input  logic [NUM_MODULES-1:0]            i_WR_ACK,
  output logic [REG_IDX_W-1:0]              o_RD_ADDR,
  input  logic [NUM_MODULES*DATA_WIDTH-1:0] i_RD_DATA,
  output logic                              o_BUSY,
  output logic                              o_ERR,
  output logic [7:0]                        o_DROP_CNT
);

  // TIMEOUT_CYCLES must be at least 1; this empty block only exists in the
  // hierarchy of a misconfigured instance, making it easy to spot.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t    state_q, state_d;
  wr_entry_t act_q, act_d;
  wr_entry_t pend_q, pend_d;
  logic      pend_vld_q, pend_vld_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic      err_q, err_d;
  logic      load;
  logic      drop;
  logic      complete;
  logic      timeout;
  logic      retire;
  wr_entry_t new_entry;

  assign new_entry = '{mod:   i_ADDR[MOD_SEL_W-1:0],
                       index: i_ADDR[MOD_SEL_W +: REG_IDX_W],
                       data:  i_DATA_IN};

  // Only the selected module's ack can complete the active write.
  assign complete = (state_q == WRITE) && i_WR_ACK[act_q.mod];

`ifdef BACKDOOR_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // tmo_cnt_q holds (cycles already high - 1) at each edge, so matching
  // TMO_LAST means this edge closes the TIMEOUT_CYCLES-th cycle high.
  assign timeout = (state_q == WRITE) && !complete && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge i_SYSCLK) begin
    if (i_RST)                          tmo_cnt_q <= '0;
    else if (load || state_q != WRITE)  tmo_cnt_q <= '0;
    else                                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // An aborted write retires exactly like an acked one.
  assign retire = complete || timeout;

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    load       = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_DOUT_VALID) begin
          state_d = WRITE;
          act_d   = new_entry;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (retire) begin
          if (pend_vld_q) begin
            // Pending moves up; a simultaneous new write refills pending.
            act_d = pend_q;
            load  = 1'b1;
            if (i_DOUT_VALID) pend_d     = new_entry;
            else              pend_vld_d = 1'b0;
          end else if (i_DOUT_VALID) begin
            act_d = new_entry;
            load  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (i_DOUT_VALID) begin
          if (!pend_vld_q) begin
            pend_d     = new_entry;
            pend_vld_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  assign err_d      = err_q | timeout;

  always_ff @(posedge i_SYSCLK) begin
    if (i_RST) begin
      state_q    <= IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (load) act_q <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    o_WR_EN = '0;
    if (state_q == WRITE) o_WR_EN[act_q.mod] = 1'b1;
  end

  assign o_WR_ADDR  = act_q.index;
  assign o_WR_DATA  = act_q.data;
  assign o_BUSY     = (state_q == WRITE) || pend_vld_q;
  assign o_ERR      = err_q;
  assign o_DROP_CNT = drop_cnt_q;
  assign o_RD_ADDR  = i_ADDR[MOD_SEL_W +: REG_IDX_W];

  backdoor_rd_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_MODULES (NUM_MODULES)
  ) u_rd_mux (
    .clk      (i_SYSCLK),
    .rst      (i_RST),
    .sel      (i_ADDR[MOD_SEL_W-1:0]),
    .rd_data  (i_RD_DATA),
    .data_out (o_DATA_OUT)
  );

endmodule

// File: tb/tb_backdoor_bus_bridge.sv
// Self-checking bench for backdoor_bus_bridge: directed vectors with
// hand-computed expectations, one task per scenario.
module tb_backdoor_bus_bridge;

`ifdef BACKDOOR_BRIDGE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    addr;
  logic [31:0]   din;
  logic          dv;
  logic [31:0]   data_out;
  logic [7:0]    wr_en;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [7:0]    ack;
  logic [3:0]    rd_addr;
  logic [255:0]  rd_data;
  logic          busy;
  logic          err;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  backdoor_bus_bridge #(
    .ADDRESS_WIDTH  (8),
    .DATA_WIDTH     (32),
    .NUM_MODULES    (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_SYSCLK     (clk),
    .i_RST        (rst),
    .i_ADDR       (addr),
    .i_DATA_IN    (din),
    .i_DOUT_VALID (dv),
    .o_DATA_OUT   (data_out),
    .o_WR_EN      (wr_en),
    .o_WR_ADDR    (wr_addr),
    .o_WR_DATA    (wr_data),
    .i_WR_ACK     (ack),
    .o_RD_ADDR    (rd_addr),
    .i_RD_DATA    (rd_data),
    .o_BUSY       (busy),
    .o_ERR        (err),
    .o_DROP_CNT   (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL reset_wr_en: got %h want %h", wr_en, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
  endtask

  task automatic test_single_write();
    addr = 7'h2B; din = 32'hDEADBEEF; dv = 1'b1;
    step();
    dv = 1'b0;
    checks++; if (wr_en !== 8'b0000_1000) begin errors++; $display("FAIL single_wr_en: got %b want 00001000", wr_en); end
    checks++; if (wr_addr !== 4'd5) begin errors++; $display("FAIL single_wr_addr: got %0d want 5", wr_addr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    // Acks from non-selected modules must be ignored.
    ack = 8'hF7;
    step();
    checks++; if (wr_en !== 8'h08) begin errors++; $display("FAIL single_foreign_ack: got %h want 08", wr_en); end
    ack = 8'h00;
    step();
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_stable: got %h want deadbeef", wr_data); end
    ack = 8'h08;
    step();
    ack = 8'h00;
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL single_done_en: got %h want 00", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    addr = 7'h11; din = 32'hA1; dv = 1'b1;   // idx 2, module 1
    step();
    addr = 7'h22; din = 32'hB2;              // idx 4, module 2 -> pending
    step();
    addr = 7'h33; din = 32'hC3;              // idx 6, module 3 -> dropped
    step();
    dv = 1'b0;
    checks++; if (wr_en !== 8'h02) begin errors++; $display("FAIL b2b_first_en: got %h want 02", wr_en); end
    checks++; if (wr_data !== 32'hA1) begin errors++; $display("FAIL b2b_first_data: got %h want a1", wr_data); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL b2b_drop: got %0d want 1", drop_cnt); end
    ack = 8'h02;
    step();
    ack = 8'h00;
    checks++; if (wr_en !== 8'h04) begin errors++; $display("FAIL b2b_second_en: got %h want 04", wr_en); end
    checks++; if (wr_addr !== 4'd4) begin errors++; $display("FAIL b2b_second_addr: got %0d want 4", wr_addr); end
    checks++; if (wr_data !== 32'hB2) begin errors++; $display("FAIL b2b_second_data: got %h want b2", wr_data); end
    ack = 8'h04;
    step();
    ack = 8'h00;
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL b2b_third_never: got %h want 00", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    addr = 7'h08; din = 32'h11; dv = 1'b1;   // idx 1, module 0
    step();
    addr = 7'h0D; din = 32'h22;              // idx 1, module 5 -> pending
    step();
    addr = 7'h7F; din = 32'h33; ack = 8'h01; // complete + valid, pending full
    step();
    dv = 1'b0; ack = 8'h00;
    checks++; if (wr_en !== 8'h20) begin errors++; $display("FAIL simul_en: got %h want 20", wr_en); end
    checks++; if (wr_data !== 32'h22) begin errors++; $display("FAIL simul_data: got %h want 22", wr_data); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL simul_drop: got %0d want 1", drop_cnt); end
    ack = 8'h20;
    step();
    ack = 8'h00;
    checks++; if (wr_en !== 8'h80) begin errors++; $display("FAIL simul_next_en: got %h want 80", wr_en); end
    checks++; if (wr_addr !== 4'hF) begin errors++; $display("FAIL simul_next_addr: got %h want f", wr_addr); end
    checks++; if (wr_data !== 32'h33) begin errors++; $display("FAIL simul_next_data: got %h want 33", wr_data); end
    ack = 8'h80;
    step();
    ack = 8'h00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle_busy: got %b want 0", busy); end
    // Bypass: completion and new valid with pending empty.
    addr = 7'h04; din = 32'h44; dv = 1'b1;   // idx 0, module 4
    step();
    addr = 7'h45; din = 32'h55; ack = 8'h10; // idx 8, module 5
    step();
    dv = 1'b0; ack = 8'h00;
    checks++; if (wr_en !== 8'h20) begin errors++; $display("FAIL bypass_en: got %h want 20", wr_en); end
    checks++; if (wr_addr !== 4'd8) begin errors++; $display("FAIL bypass_addr: got %0d want 8", wr_addr); end
    checks++; if (wr_data !== 32'h55) begin errors++; $display("FAIL bypass_data: got %h want 55", wr_data); end
    ack = 8'h20;
    step();
    ack = 8'h00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    addr = 7'h02; din = 32'h66; dv = 1'b1;   // idx 0, module 2
    step();
    dv = 1'b0;
    checks++; if (wr_en !== 8'h04) begin errors++; $display("FAIL tmo_start_en: got %h want 04", wr_en); end
`ifdef BACKDOOR_BRIDGE_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (wr_en !== 8'h04) begin errors++; $display("FAIL tmo_hold_en cycle %0d: got %h want 04", k, wr_en); end
    end
    step();
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL tmo_abort_en: got %h want 00", wr_en); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b want 1", err); end
    step();
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
`else
    begin
      int bad_cycle = -1;
      for (int k = 0; k < 1000; k++) begin
        step();
        if (wr_en !== 8'h04 && bad_cycle < 0) bad_cycle = k;
      end
      checks++; if (bad_cycle >= 0) begin errors++; $display("FAIL notmo_hold: wr_en left 04 at cycle %0d, got %h", bad_cycle, wr_en); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL notmo_err: got %b want 0", err); end
    ack = 8'h04;
    step();
    ack = 8'h00;
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL notmo_late_ack: got %h want 00", wr_en); end
`endif
  endtask

  task automatic test_readback();
    for (int k = 0; k < 8; k++) rd_data[k*32 +: 32] = 32'h1111_1111 * k;
    rd_data[6*32 +: 32] = 32'h12345678;
    addr = {4'h9, 3'd6};
    #1;
    checks++; if (rd_addr !== 4'h9) begin errors++; $display("FAIL rb_rd_addr: got %h want 9", rd_addr); end
    step();
    checks++; if (data_out !== 32'h12345678) begin errors++; $display("FAIL rb_mod6: got %h want 12345678", data_out); end
    addr = {4'h3, 3'd2};
    #1;
    checks++; if (rd_addr !== 4'h3) begin errors++; $display("FAIL rb_rd_addr2: got %h want 3", rd_addr); end
    checks++; if (data_out !== 32'h12345678) begin errors++; $display("FAIL rb_latency: got %h want 12345678", data_out); end
    step();
    checks++; if (data_out !== 32'h22222222) begin errors++; $display("FAIL rb_mod2: got %h want 22222222", data_out); end
    rd_data[2*32 +: 32] = 32'hCAFEF00D;
    step();
    checks++; if (data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL rb_data_change: got %h want cafef00d", data_out); end
  endtask

  task automatic test_reset_mid_write();
    addr = 7'h01; din = 32'h77; dv = 1'b1;   // module 1 active
    step();
    addr = 7'h0C; din = 32'h88;              // module 4 pending
    step();
    addr = 7'h13; din = 32'h99;              // dropped
    step();
    dv = 1'b0;
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL rst_pre_drop: got %0d want 2", drop_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL rst_mid_en: got %h want 00", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", err); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_mid_drop: got %0d want 0", drop_cnt); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_data_out: got %h want 0", data_out); end
    ack = 8'hFF;
    begin
      int bad_cycle = -1;
      for (int k = 0; k < 5; k++) begin
        step();
        if (wr_en !== 8'h00 && bad_cycle < 0) bad_cycle = k;
      end
      checks++; if (bad_cycle >= 0) begin errors++; $display("FAIL rst_pending_issued: wr_en %h at cycle %0d want 00", wr_en, bad_cycle); end
    end
    ack = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr = '0; din = '0; dv = 1'b0; ack = '0; rd_data = '0;
    step();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_simultaneous();
    test_timeout();
    test_readback();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
